// File: rtl/uart_tx_fifo.sv
// UART transmitter with a power-of-two transmit FIFO. Frame format (data bits,
// parity, stop bits) is fixed by parameters; queued characters go out back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_TX_DV,
  input  logic [DATA_BITS-1:0]          i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_TX_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_TX_Active,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 1023) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be 2..1023");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..256");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] r_Mem [FIFO_DEPTH];
  logic [AW-1:0]        r_Wr_Ptr, r_Rd_Ptr;
  logic [CW-1:0]        r_Count;
  logic                 r_Ready, r_Overflow;
  state_t               r_State;
  logic [TW-1:0]        r_Clk_Cnt;
  logic [BW-1:0]        r_Bit_Idx;
  logic [DATA_BITS-1:0] r_Shift;
  logic                 r_Parity, r_Serial, r_Active, r_Done;

  logic                 w_Push, w_Pop, w_Bit_End;
  logic [CW-1:0]        w_Count_Next;
  logic [DATA_BITS-1:0] w_Head;

  // Push is gated by the registered ready flag, so a same-cycle pop never frees a full slot.
  assign w_Push       = i_TX_DV & r_Ready;
  assign w_Pop        = (r_State == S_IDLE) && (r_Count != '0);
  assign w_Count_Next = r_Count + CW'(w_Push) - CW'(w_Pop);
  assign w_Head       = r_Mem[r_Rd_Ptr];
  assign w_Bit_End    = (r_Clk_Cnt == BIT_LAST);

  always_ff @(posedge i_Clock) begin
    if (w_Push) r_Mem[r_Wr_Ptr] <= i_TX_Byte;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Wr_Ptr   <= '0;
      r_Rd_Ptr   <= '0;
      r_Count    <= '0;
      r_Ready    <= 1'b1;
      r_Overflow <= 1'b0;
    end else begin
      if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + AW'(1);
      if (w_Pop)  r_Rd_Ptr <= r_Rd_Ptr + AW'(1);
      r_Count    <= w_Count_Next;
      r_Ready    <= (w_Count_Next != CNT_FULL);
      r_Overflow <= i_TX_DV & ~r_Ready;
    end
  end

  // The line register samples the current state, so o_TX_Serial lags the state by one edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State   <= S_IDLE;
      r_Clk_Cnt <= '0;
      r_Bit_Idx <= '0;
      r_Shift   <= '0;
      r_Parity  <= 1'b0;
      r_Serial  <= 1'b1;
      r_Active  <= 1'b0;
      r_Done    <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      unique case (r_State)
        S_IDLE: begin
          r_Serial <= 1'b1;
          if (w_Pop) begin
            r_Shift   <= w_Head;
            r_Parity  <= (PARITY == 1) ? ~^w_Head : ^w_Head;
            r_Active  <= 1'b1;
            r_Clk_Cnt <= '0;
            r_State   <= S_START;
          end
        end
        S_START: begin
          r_Serial <= 1'b0;
          if (w_Bit_End) begin
            r_Clk_Cnt <= '0;
            r_Bit_Idx <= '0;
            r_State   <= S_DATA;
          end else begin
            r_Clk_Cnt <= r_Clk_Cnt + TW'(1);
          end
        end
        S_DATA: begin
          r_Serial <= r_Shift[0];
          if (w_Bit_End) begin
            r_Clk_Cnt <= '0;
            r_Shift   <= r_Shift >> 1;
            if (r_Bit_Idx == IDX_LAST) begin
              r_State <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_Bit_Idx <= r_Bit_Idx + BW'(1);
            end
          end else begin
            r_Clk_Cnt <= r_Clk_Cnt + TW'(1);
          end
        end
        S_PARITY: begin
          r_Serial <= r_Parity;
          if (w_Bit_End) begin
            r_Clk_Cnt <= '0;
            r_State   <= S_STOP;
          end else begin
            r_Clk_Cnt <= r_Clk_Cnt + TW'(1);
          end
        end
        S_STOP: begin
          r_Serial <= 1'b1;
          if (r_Clk_Cnt == STOP_LAST) begin
            r_Clk_Cnt <= '0;
            r_State   <= S_IDLE;
            r_Done    <= 1'b1;
            r_Active  <= 1'b0;
          end else begin
            r_Clk_Cnt <= r_Clk_Cnt + TW'(1);
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_TX_Ready    = r_Ready;
  assign o_TX_Overflow = r_Overflow;
  assign o_FIFO_Count  = r_Count;
  assign o_TX_Active   = r_Active;
  assign o_TX_Serial   = r_Serial;
  assign o_TX_Done     = r_Done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame formats share one stimulus stream and are
// checked every cycle against a queue/timeline model, plus directed frame tables.
module tb_uart_tx_fifo;

  localparam int NI = 3;
  localparam int unsigned MC [NI] = '{4, 3, 4};
  localparam int unsigned MD [NI] = '{8, 7, 8};
  localparam int unsigned MP [NI] = '{2, 1, 0};
  localparam int unsigned MS [NI] = '{1, 2, 1};
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv  = 1'b0;
  logic [7:0] tx_byte = '0;
  logic [NI-1:0] rdy, ovf, act, ser, done;
  logic [2:0]    cnt [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
    .o_TX_Ready(rdy[0]), .o_TX_Overflow(ovf[0]), .o_FIFO_Count(cnt[0]),
    .o_TX_Active(act[0]), .o_TX_Serial(ser[0]), .o_TX_Done(done[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte[6:0]),
    .o_TX_Ready(rdy[1]), .o_TX_Overflow(ovf[1]), .o_FIFO_Count(cnt[1]),
    .o_TX_Active(act[1]), .o_TX_Serial(ser[1]), .o_TX_Done(done[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
    .o_TX_Ready(rdy[2]), .o_TX_Overflow(ovf[2]), .o_FIFO_Count(cnt[2]),
    .o_TX_Active(act[2]), .o_TX_Serial(ser[2]), .o_TX_Done(done[2]));

  // ---------------- reference model ----------------
  logic [7:0]  m_fifo [NI][DEPTH];
  logic [7:0]  m_char [NI];
  int unsigned m_cnt [NI], m_head [NI], m_t [NI];
  bit          m_busy [NI];
  logic        m_ser [NI], m_act [NI], m_done [NI], m_ovf [NI], m_rdy [NI];

  function automatic int unsigned nbits(int k);
    return 1 + MD[k] + ((MP[k] != 0) ? 1 : 0) + MS[k];
  endfunction

  function automatic logic frame_bit(int k, logic [7:0] ch, int unsigned i);
    int unsigned ones;
    if (i == 0) return 1'b0;
    if (i <= MD[k]) return ch[i-1];
    if (MP[k] != 0 && i == MD[k] + 1) begin
      ones = 0;
      for (int unsigned b = 0; b < MD[k]; b++) ones += ch[b];
      return (MP[k] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_cnt[k] = 0; m_head[k] = 0; m_t[k] = 0; m_busy[k] = 0; m_char[k] = '0;
      m_ser[k] = 1'b1; m_act[k] = 1'b0; m_done[k] = 1'b0; m_ovf[k] = 1'b0; m_rdy[k] = 1'b1;
    end
  endtask

  task automatic model_step(logic d, logic [7:0] b);
    bit push, pop;
    for (int k = 0; k < NI; k++) begin
      push = d && m_rdy[k];
      pop  = !m_busy[k] && m_cnt[k] > 0;
      m_ovf[k]  = d && !m_rdy[k];
      m_done[k] = 1'b0;
      if (push) m_fifo[k][(m_head[k] + m_cnt[k]) % DEPTH] = b;
      if (m_busy[k]) begin
        m_t[k]++;
        m_ser[k] = frame_bit(k, m_char[k], (m_t[k] - 1) / MC[k]);
        if (m_t[k] == nbits(k) * MC[k]) begin
          m_done[k] = 1'b1; m_act[k] = 1'b0; m_busy[k] = 0;
        end
      end else begin
        m_ser[k] = 1'b1;
        if (pop) begin
          m_char[k] = m_fifo[k][m_head[k]];
          m_head[k] = (m_head[k] + 1) % DEPTH;
          m_busy[k] = 1; m_t[k] = 0; m_act[k] = 1'b1;
        end
      end
      m_cnt[k] = m_cnt[k] + (push ? 1 : 0) - (pop ? 1 : 0);
      m_rdy[k] = (m_cnt[k] != DEPTH);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step(dv, tx_byte);
    end
  end

  task automatic chk(string name, int k, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s u%0d t=%0t got=%0d exp=%0d", name, k, $time, got, exp);
    end
  endtask

  // Every cycle, every instance: {ready, overflow, count, active, serial, done}.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("model", k, {rdy[k], ovf[k], cnt[k], act[k], ser[k], done[k]},
            {m_rdy[k], m_ovf[k], 3'(m_cnt[k]), m_act[k], m_ser[k], m_done[k]});
      end
    end
  end

  // ---------------- directed frame table ----------------
  typedef struct {
    logic [7:0]        ch;
    logic [2:0][12:0]  f;   // f[k] bit i = i-th line bit for instance k
  } vec_t;
  vec_t vecs [5];

  task automatic set_vec(int i, logic [7:0] ch, logic [12:0] f0, logic [12:0] f1, logic [12:0] f2);
    vecs[i].ch = ch; vecs[i].f[0] = f0; vecs[i].f[1] = f1; vecs[i].f[2] = f2;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      ok = (act == '0) && (cnt[0] == 0) && (cnt[1] == 0) && (cnt[2] == 0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle timeout t=%0t", $time);
    end
  endtask

  task automatic run_vec(int v);
    int unsigned i, len;
    @(negedge clk); dv = 1'b1; tx_byte = vecs[v].ch;
    @(negedge clk); dv = 1'b0;
    for (int unsigned c = 1; c <= 46; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        len = nbits(k) * MC[k];
        if (c == 1) chk("serial_before_fall", k, ser[k], 1);
        if (c >= 2 && (c - 2) % MC[k] == 1) begin
          i = (c - 2) / MC[k];
          if (i < nbits(k)) chk("frame_bit", k, ser[k], vecs[v].f[k][i]);
        end
        if (c == len)     chk("done_early", k, done[k], 0);
        if (c == len + 1) chk("done_pulse", k, done[k], 1);
      end
    end
    wait_idle();
  endtask

  initial begin
    set_vec(0, 8'hA5, 13'({1'b1, 1'b0, 8'hA5, 1'b0}), 13'({2'b11, 1'b0, 7'h25, 1'b0}), 13'({1'b1, 8'hA5, 1'b0}));
    set_vec(1, 8'h07, 13'({1'b1, 1'b1, 8'h07, 1'b0}), 13'({2'b11, 1'b0, 7'h07, 1'b0}), 13'({1'b1, 8'h07, 1'b0}));
    set_vec(2, 8'h41, 13'({1'b1, 1'b0, 8'h41, 1'b0}), 13'({2'b11, 1'b1, 7'h41, 1'b0}), 13'({1'b1, 8'h41, 1'b0}));
    set_vec(3, 8'h80, 13'({1'b1, 1'b1, 8'h80, 1'b0}), 13'({2'b11, 1'b1, 7'h00, 1'b0}), 13'({1'b1, 8'h80, 1'b0}));
    set_vec(4, 8'hFF, 13'({1'b1, 1'b0, 8'hFF, 1'b0}), 13'({2'b11, 1'b0, 7'h7F, 1'b0}), 13'({1'b1, 8'hFF, 1'b0}));

    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_ready", k, rdy[k], 1);
      chk("reset_serial", k, ser[k], 1);
    end
    #1 rst = 1'b0;

    for (int v = 0; v < 5; v++) run_vec(v);

    // Six back-to-back writes into a depth-4 FIFO: the sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); dv = 1'b1; tx_byte = 8'(i + 1);
      if (i == 5) begin
        chk("full_count", 2, cnt[2], 4);
        chk("full_ready", 2, rdy[2], 0);
      end
    end
    @(negedge clk); dv = 1'b0;
    chk("overflow_pulse", 2, ovf[2], 1);
    chk("overflow_count", 2, cnt[2], 4);
    @(negedge clk);
    chk("overflow_clear", 2, ovf[2], 0);
    wait_idle();

    // Push on the same edge as the IDLE pop with one character queued (u2 timing).
    @(negedge clk); dv = 1'b1; tx_byte = 8'h3C;
    @(negedge clk); tx_byte = 8'hC3;
    @(negedge clk); dv = 1'b0;
    repeat (40) @(negedge clk);
    chk("gap_done", 2, done[2], 1);
    chk("gap_count", 2, cnt[2], 1);
    dv = 1'b1; tx_byte = 8'h5A;
    @(negedge clk); dv = 1'b0;
    chk("pushpop_count", 2, cnt[2], 1);
    chk("pushpop_active", 2, act[2], 1);
    wait_idle();

    // Asynchronous reset in the middle of the data bits with two characters queued.
    @(negedge clk); dv = 1'b1; tx_byte = 8'h00;
    @(negedge clk); tx_byte = 8'h11;
    @(negedge clk); tx_byte = 8'h22;
    @(negedge clk); dv = 1'b0;
    chk("queued_before_reset", 2, cnt[2], 2);
    repeat (13) @(negedge clk);
    chk("in_data_low", 2, ser[2], 0);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("async_serial", k, ser[k], 1);
      chk("async_active", k, act[k], 0);
      chk("async_count", k, cnt[k], 0);
    end
    @(negedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    run_vec(1);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      dv = ($urandom_range(0, 99) < 25);
      tx_byte = 8'($urandom);
    end
    @(negedge clk); dv = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
